cmp_nibble_serial: RTL and testbench

- Sequential magnitude comparator; same LT/EQ/GT cascade semantics as the team's 4-bit comparator stage, but time-multiplexed.
- Operands A and B are compared one nibble per clock, LSB nibble first. Each nibble result is folded into a running LT/EQ/GT state.
- Sits upstream of wider cascades: its registered LT/EQ/GT result is the cascade input of the next comparator stage.
- Valid/ready handshake on both sides.

---
 rtl/cmp_nibble_serial_pkg.sv | 39 +++
 rtl/cmp_nibble_serial_step.sv | 21 ++
 rtl/cmp_nibble_serial.sv | 127 ++++++++++++
 tb/tb_cmp_nibble_serial.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_nibble_serial_pkg.sv
// Shared encodings for the nibble-serial magnitude comparator.
// The build macro CMP_NIBBLE_EARLY_EXIT_EN selects an MSB-first early-exit scan.
package cmp_nibble_serial_pkg;

    localparam int CMP_NIB = 4;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_BUSY = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_e;

    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_LT = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;

    // GT wins over LT; EQin carries no extra information.
    function automatic logic [1:0] cmp_seed(input logic lt, input logic gt);
        if (gt) begin
            return CMP_GT;
        end
        if (lt) begin
            return CMP_LT;
        end
        return CMP_EQ;
    endfunction

    function automatic logic [2:0] cmp_onehot(input logic [1:0] res);
        logic [2:0] oh;
        oh = 3'b010;
        unique case (res)
            CMP_LT:  oh = 3'b100;
            CMP_GT:  oh = 3'b001;
            default: oh = 3'b010;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cmp_nibble_serial_step.sv
// One nibble of the comparator cascade: an unequal nibble overrides the
// incoming result, an equal nibble passes it through.
module cmp_nibble_step
    import cmp_nibble_serial_pkg::*;
(
    input  logic [CMP_NIB-1:0] i_a,
    input  logic [CMP_NIB-1:0] i_b,
    input  logic [1:0]         i_prev,
    output logic [1:0]         o_next
);

    always_comb begin
        o_next = i_prev;
        if (i_a < i_b) begin
            o_next = CMP_LT;
        end else if (i_a > i_b) begin
            o_next = CMP_GT;
        end
    end

endmodule

// File: rtl/cmp_nibble_serial.sv
// Time-multiplexed LT/EQ/GT comparator, one nibble per clock.
// Define CMP_NIBBLE_EARLY_EXIT_EN for an MSB-first scan that stops early.
module cmp_nibble_serial
    import cmp_nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             LTin,
    input  logic             EQin,
    input  logic             GTin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             LTout,
    output logic             EQout,
    output logic             GTout
);

    localparam int NNIB = WIDTH / CMP_NIB;
    localparam int IW   = $clog2(NNIB);

    cmp_state_e         r_state;
    cmp_state_e         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IW-1:0]      r_idx;
    logic [1:0]         r_run;
    logic [2:0]         r_res;
    logic [CMP_NIB-1:0] w_na;
    logic [CMP_NIB-1:0] w_nb;
    logic [1:0]         w_next;
    logic               w_last;
    logic               w_accept;
    logic [IW-1:0]      w_idx_start;
    logic [IW-1:0]      w_idx_step;
    logic               w_unused_eqin;

    assign w_unused_eqin = EQin;
    assign w_accept      = in_valid && in_ready;

    always_comb begin
        w_na = '0;
        w_nb = '0;
        for (int k = 0; k < NNIB; k++) begin
            if (r_idx == IW'(k)) begin
                w_na = r_a[k*CMP_NIB +: CMP_NIB];
                w_nb = r_b[k*CMP_NIB +: CMP_NIB];
            end
        end
    end

    cmp_nibble_step u_step (
        .i_a    (w_na),
        .i_b    (w_nb),
        .i_prev (r_run),
        .o_next (w_next)
    );

`ifdef CMP_NIBBLE_EARLY_EXIT_EN
    // Seed rides in r_run untouched until a nibble differs, so it lands last.
    assign w_idx_start = IW'(NNIB - 1);
    assign w_idx_step  = r_idx - 1'b1;
    assign w_last      = (r_idx == '0) || (w_na != w_nb);
`else
    assign w_idx_start = '0;
    assign w_idx_step  = r_idx + 1'b1;
    assign w_last      = (r_idx == IW'(NNIB - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CMP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            CMP_IDLE: if (w_accept)  w_state_nxt = CMP_BUSY;
            CMP_BUSY: if (w_last)    w_state_nxt = CMP_DONE;
            CMP_DONE: if (out_ready) w_state_nxt = CMP_IDLE;
            default:                 w_state_nxt = CMP_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == CMP_IDLE) && !rst;
        out_valid = (r_state == CMP_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_run <= CMP_EQ;
            r_res <= '0;
        end else begin
            if (r_state == CMP_IDLE && w_accept) begin
                r_a   <= A;
                r_b   <= B;
                r_idx <= w_idx_start;
                r_run <= cmp_seed(LTin, GTin);
            end
            if (r_state == CMP_BUSY) begin
                r_run <= w_next;
                r_idx <= w_idx_step;
                if (w_last) begin
                    r_res <= cmp_onehot(w_next);
                end
            end
        end
    end

    assign LTout = r_res[2];
    assign EQout = r_res[1];
    assign GTout = r_res[0];

endmodule

// File: tb/tb_cmp_nibble_serial.sv
// Self-checking bench for cmp_nibble_serial at WIDTH=16 and WIDTH=8.
// Expected latency follows CMP_NIBBLE_EARLY_EXIT_EN when it is defined.
module tb_cmp_nibble_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        LTin, EQin, GTin;
    logic        iv16, or16, ir16, ov16, lt16, eq16, gt16;
    logic        iv8, or8, ir8, ov8, lt8, eq8, gt8;

    int total = 0;
    int bad   = 0;

    cmp_nibble_serial #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .A(A), .B(B),
        .LTin(LTin), .EQin(EQin), .GTin(GTin),
        .out_valid(ov16), .out_ready(or16),
        .LTout(lt16), .EQout(eq16), .GTout(gt16)
    );

    cmp_nibble_serial #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .A(A[7:0]), .B(B[7:0]),
        .LTin(LTin), .EQin(EQin), .GTin(GTin),
        .out_valid(ov8), .out_ready(or8),
        .LTout(lt8), .EQout(eq8), .GTout(gt8)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] res(input int sel);
        return (sel != 0) ? {lt8, eq8, gt8} : {lt16, eq16, gt16};
    endfunction

    function automatic logic ovf(input int sel);
        return (sel != 0) ? ov8 : ov16;
    endfunction

    function automatic logic irf(input int sel);
        return (sel != 0) ? ir8 : ir16;
    endfunction

    task automatic set_iv(input int sel, input logic v);
        if (sel != 0) iv8 = v;
        else          iv16 = v;
    endtask

    task automatic set_or(input int sel, input logic v);
        if (sel != 0) or8 = v;
        else          or16 = v;
    endtask

    // Reference: plain magnitude compare, cascade seed only on equality.
    function automatic logic [2:0] ref_res(input logic [15:0] a,
        input logic [15:0] b, input logic lt, input logic gt, input int w);
        int ai, bi;
        ai = int'(a) % (1 << w);
        bi = int'(b) % (1 << w);
        if (ai < bi) return 3'b100;
        if (ai > bi) return 3'b001;
        if (gt)      return 3'b001;
        if (lt)      return 3'b100;
        return 3'b010;
    endfunction

    function automatic int ref_lat(input logic [15:0] a,
        input logic [15:0] b, input int w);
`ifdef CMP_NIBBLE_EARLY_EXIT_EN
        for (int k = w / 4 - 1; k >= 0; k--) begin
            if ((int'(a) / (1 << (4 * k))) % 16 != (int'(b) / (1 << (4 * k))) % 16)
                return w / 4 - k;
        end
        return w / 4;
`else
        if (a == b) return w / 4;
        return w / 4;
`endif
    endfunction

    task automatic txn(input int sel, input logic [15:0] a,
        input logic [15:0] b, input logic lt, input logic eq,
        input logic gt, input int hold);
        int          w;
        int          n;
        int          el;
        logic [2:0]  er;
        w  = (sel != 0) ? 8 : 16;
        er = ref_res(a, b, lt, gt, w);
        el = ref_lat(a, b, w);
        n  = 0;
        while (!irf(sel) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(irf(sel)), 32'd1);
        A = a; B = b; LTin = lt; EQin = eq; GTin = gt;
        set_iv(sel, 1'b1);
        @(posedge clk); #1;
        set_iv(sel, 1'b0);
        A = 16'($urandom);
        B = 16'($urandom);
        {LTin, EQin, GTin} = 3'($urandom);
        n = 0;
        while (!ovf(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(el));
        check("result", 32'(res(sel)), 32'(er));
        for (int h = 0; h < hold; h++) begin
            set_iv(sel, 1'b1);
            @(posedge clk); #1;
            check("hold_valid", 32'(ovf(sel)), 32'd1);
            check("hold_result", 32'(res(sel)), 32'(er));
            check("hold_no_accept", 32'(irf(sel)), 32'd0);
        end
        set_iv(sel, 1'b0);
        set_or(sel, 1'b1);
        @(posedge clk); #1;
        set_or(sel, 1'b0);
        check("post_valid", 32'(ovf(sel)), 32'd0);
        check("post_ready", 32'(irf(sel)), 32'd1);
        check("post_result_hold", 32'(res(sel)), 32'(er));
    endtask

    initial begin
        logic [15:0] a, b;
        logic [2:0]  c;
        int          w;
        int          seen;
        rst  = 1'b1;
        A    = '0; B = '0;
        LTin = 1'b0; EQin = 1'b0; GTin = 1'b0;
        iv16 = 1'b0; or16 = 1'b0;
        iv8  = 1'b0; or8  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready16", 32'(ir16), 32'd0);
        check("rst_ready8", 32'(ir8), 32'd0);
        check("rst_valid16", 32'(ov16), 32'd0);
        check("rst_result16", 32'(res(0)), 32'd0);
        check("rst_result8", 32'(res(1)), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(ir16), 32'd1);

        txn(0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 0);
        txn(0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0);
        txn(0, 16'h00FF, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
        txn(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3);
        txn(1, 16'h00A5, 16'h00A5, 1'b1, 1'b0, 1'b0, 0);

        A = 16'hFFFF; B = 16'h0000;
        LTin = 1'b0; EQin = 1'b0; GTin = 1'b0;
        iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_ready_low", 32'(ir16), 32'd0);
        @(posedge clk); #1;
        check("midrst_valid", 32'(ov16), 32'd0);
        check("midrst_result", 32'(res(0)), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready", 32'(ir16), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ov16 || res(0) != 3'b000) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);

        for (int sel = 0; sel < 2; sel++) begin
            w = (sel != 0) ? 8 : 16;
            for (int i = 0; i < 1500; i++) begin
                a = 16'($urandom);
                if (w == 8) a[15:8] = 8'h00;
                case ($urandom_range(0, 3))
                    0: b = a;
                    1: b = a ^ (16'($urandom_range(1, 15))
                               << (4 * $urandom_range(0, w / 4 - 1)));
                    default: b = 16'($urandom);
                endcase
                if (w == 8) b[15:8] = 8'h00;
                c = 3'($urandom);
                txn(sel, a, b, c[2], c[1], c[0], 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
